lsb_queue: RTL and testbench

//  Parametrised in-order load/store buffer between dispatch and memctrl in the Tomasulo RV32I core.

---
 rtl/lsb_queue_if.sv | 57 +++++
 rtl/lsb_queue.sv | 227 ++++++++++++++++++++++
 tb/tb_lsb_queue.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsb_queue_if.sv
// Bundle of dispatch, CDB, commit, memory and result signals for the load/store buffer.
// Latency: none, wires only.
// Backpressure: nxt_full tells dispatch to stop issuing; mem_done paces memory requests.
interface lsb_queue_if #(
    parameter int ROB_W = 4,
    parameter int CDB_N = 2
);
    logic                   rdy;
    logic                   rollback;
    logic                   nxt_full;
    logic                   issue;
    logic                   issue_is_store;
    logic [2:0]             issue_funct3;
    logic [ROB_W-1:0]       issue_rob_pos;
    logic                   issue_rs1_busy;
    logic [ROB_W-1:0]       issue_rs1_tag;
    logic [31:0]            issue_rs1_val;
    logic                   issue_rs2_busy;
    logic [ROB_W-1:0]       issue_rs2_tag;
    logic [31:0]            issue_rs2_val;
    logic [31:0]            issue_imm;
    logic [CDB_N-1:0]       cdb_valid;
    logic [CDB_N*ROB_W-1:0] cdb_rob_pos;
    logic [CDB_N*32-1:0]    cdb_val;
    logic                   commit_store;
    logic [ROB_W-1:0]       commit_rob_pos;
    logic                   mem_en;
    logic                   mem_wr;
    logic [31:0]            mem_addr;
    logic [2:0]             mem_len;
    logic [31:0]            mem_wdata;
    logic                   mem_done;
    logic [31:0]            mem_rdata;
    logic                   result_valid;
    logic [ROB_W-1:0]       result_rob_pos;
    logic [31:0]            result_val;

    modport master (
        output rdy, rollback, issue, issue_is_store, issue_funct3, issue_rob_pos,
               issue_rs1_busy, issue_rs1_tag, issue_rs1_val,
               issue_rs2_busy, issue_rs2_tag, issue_rs2_val, issue_imm,
               cdb_valid, cdb_rob_pos, cdb_val, commit_store, commit_rob_pos,
               mem_done, mem_rdata,
        input  nxt_full, mem_en, mem_wr, mem_addr, mem_len, mem_wdata,
               result_valid, result_rob_pos, result_val
    );

    modport slave (
        input  rdy, rollback, issue, issue_is_store, issue_funct3, issue_rob_pos,
               issue_rs1_busy, issue_rs1_tag, issue_rs1_val,
               issue_rs2_busy, issue_rs2_tag, issue_rs2_val, issue_imm,
               cdb_valid, cdb_rob_pos, cdb_val, commit_store, commit_rob_pos,
               mem_done, mem_rdata,
        output nxt_full, mem_en, mem_wr, mem_addr, mem_len, mem_wdata,
               result_valid, result_rob_pos, result_val
    );
endinterface

// File: rtl/lsb_queue.sv
// In-order load/store buffer: snoops the CDB for operands, issues head op to memory, returns loads.
// Latency: issue -> mem_en >= 1 cycle; mem_done -> result_valid 1 cycle.
// Backpressure: nxt_full stops dispatch; one outstanding memory request, held until mem_done.
// Option LSB_IO_WAIT_EN: MMIO loads (addr[17:16]==2'b11) wait until io_rob_head equals their rob_pos.
module lsb_queue #(
    parameter int DEPTH = 8,
    parameter int ROB_W = 4,
    parameter int CDB_N = 2
) (
    input  logic             clk,
    input  logic             rst,
`ifdef LSB_IO_WAIT_EN
    input  logic [ROB_W-1:0] io_rob_head,
`endif
    lsb_queue_if.slave       bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    typedef struct packed {
        logic             vld;
        logic             is_store;
        logic             committed;
        logic [2:0]       funct3;
        logic [ROB_W-1:0] rob_pos;
        logic             rs1_busy;
        logic [ROB_W-1:0] rs1_tag;
        logic [31:0]      rs1_val;
        logic             rs2_busy;
        logic [ROB_W-1:0] rs2_tag;
        logic [31:0]      rs2_val;
        logic [31:0]      imm;
    } ent_t;

    ent_t          q [DEPTH];
    ent_t          h, new_ent;
    logic [PW-1:0] head, tail, scan_idx, commit_idx;
    logic [CW-1:0] count, committed_cnt, count_n, count_rb;
    state_t        state, state_n;
    logic          drop, drop_n;
    logic          can_fire, pop, pop_store, do_issue, commit_hit, io_ok;
    logic [31:0]   req_addr;
    logic [32:0]   cap1 [DEPTH];
    logic [32:0]   cap2 [DEPTH];
    logic [32:0]   byp1, byp2;

    // {hit, value} for a tag; lower channel indices override higher ones.
    function automatic logic [32:0] cdb_match(input logic [ROB_W-1:0] tag,
                                              input logic [CDB_N-1:0] v,
                                              input logic [CDB_N*ROB_W-1:0] tags,
                                              input logic [CDB_N*32-1:0] vals);
        logic [32:0] r;
        r = '0;
        for (int k = CDB_N - 1; k >= 0; k--)
            if (v[k] && tags[k*ROB_W +: ROB_W] == tag) r = {1'b1, vals[k*32 +: 32]};
        return r;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  load_ext = {{24{d[7]}}, d[7:0]};
            3'b001:  load_ext = {{16{d[15]}}, d[15:0]};
            3'b100:  load_ext = {24'd0, d[7:0]};
            3'b101:  load_ext = {16'd0, d[15:0]};
            default: load_ext = d;
        endcase
    endfunction

    function automatic logic [2:0] access_len(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   access_len = 3'd1;
            2'b01:   access_len = 3'd2;
            default: access_len = 3'd4;
        endcase
    endfunction

    assign h        = q[head];
    assign req_addr = h.rs1_val + h.imm;

`ifdef LSB_IO_WAIT_EN
    assign io_ok = h.is_store || (req_addr[17:16] != 2'b11) || (io_rob_head == h.rob_pos);
`else
    assign io_ok = 1'b1;
`endif

    // A dropped (rolled-back) load in flight completes without popping; the entry is already gone.
    assign can_fire  = (state == IDLE) && h.vld && !h.rs1_busy && !h.rs2_busy &&
                       (!h.is_store || h.committed) && !bus.rollback && io_ok;
    assign pop       = (state == WAIT_MEM) && bus.mem_done && !drop && !(bus.rollback && !h.is_store);
    assign pop_store = pop && h.is_store;
    // When full, the head slot being popped this cycle can take the new op.
    assign do_issue  = bus.issue && !bus.rollback && ((count != CW'(DEPTH)) || pop);
    assign count_n   = count + CW'(do_issue) - CW'(pop);
    assign count_rb  = committed_cnt - CW'(pop_store);
    assign bus.nxt_full = bus.rdy ? (((bus.rollback ? count_rb : count_n)) == CW'(DEPTH))
                                  : (count == CW'(DEPTH));

    // Find the oldest uncommitted store owned by the committing ROB entry.
    always_comb begin
        commit_hit = 1'b0;
        commit_idx = '0;
        scan_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head + PW'(i);
            if (!commit_hit && bus.commit_store && q[scan_idx].vld && q[scan_idx].is_store &&
                !q[scan_idx].committed && q[scan_idx].rob_pos == bus.commit_rob_pos) begin
                commit_hit = 1'b1;
                commit_idx = scan_idx;
            end
        end
    end

    // CDB snoop results for every stored operand and for the op being issued.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cap1[i] = cdb_match(q[i].rs1_tag, bus.cdb_valid, bus.cdb_rob_pos, bus.cdb_val);
            cap2[i] = cdb_match(q[i].rs2_tag, bus.cdb_valid, bus.cdb_rob_pos, bus.cdb_val);
        end
        byp1 = cdb_match(bus.issue_rs1_tag, bus.cdb_valid, bus.cdb_rob_pos, bus.cdb_val);
        byp2 = cdb_match(bus.issue_rs2_tag, bus.cdb_valid, bus.cdb_rob_pos, bus.cdb_val);
    end

    // Entry written at the tail, with same-cycle CDB bypass on busy operands.
    always_comb begin
        new_ent          = '0;
        new_ent.vld      = 1'b1;
        new_ent.is_store = bus.issue_is_store;
        new_ent.funct3   = bus.issue_funct3;
        new_ent.rob_pos  = bus.issue_rob_pos;
        new_ent.imm      = bus.issue_imm;
        new_ent.rs1_tag  = bus.issue_rs1_tag;
        new_ent.rs1_busy = bus.issue_rs1_busy && !byp1[32];
        new_ent.rs1_val  = bus.issue_rs1_busy ? byp1[31:0] : bus.issue_rs1_val;
        new_ent.rs2_tag  = bus.issue_rs2_tag;
        new_ent.rs2_busy = bus.issue_rs2_busy && !byp2[32];
        new_ent.rs2_val  = bus.issue_rs2_busy ? byp2[31:0] : bus.issue_rs2_val;
    end

    // Memory FSM state and drop flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            drop  <= 1'b0;
        end else if (bus.rdy) begin
            state <= state_n;
            drop  <= drop_n;
        end
    end

    // Memory FSM next state: one request in flight; a rollback marks an in-flight load as dropped.
    always_comb begin
        state_n = state;
        drop_n  = drop;
        case (state)
            IDLE: if (can_fire) state_n = WAIT_MEM;
            WAIT_MEM: begin
                if (bus.rollback && !h.is_store) drop_n = 1'b1;
                if (bus.mem_done) begin
                    state_n = IDLE;
                    drop_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Queue storage, pointers, counters, memory request and load result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            committed_cnt      <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            bus.mem_en         <= 1'b0;
            bus.mem_wr         <= 1'b0;
            bus.mem_addr       <= '0;
            bus.mem_len        <= '0;
            bus.mem_wdata      <= '0;
            bus.result_valid   <= 1'b0;
            bus.result_rob_pos <= '0;
            bus.result_val     <= '0;
        end else if (bus.rdy) begin
            bus.mem_en <= can_fire;
            if (can_fire) begin
                bus.mem_wr    <= h.is_store;
                bus.mem_addr  <= req_addr;
                bus.mem_len   <= access_len(h.funct3);
                bus.mem_wdata <= h.rs2_val;
            end
            bus.result_valid <= pop && !h.is_store;
            if (pop && !h.is_store) begin
                bus.result_rob_pos <= h.rob_pos;
                bus.result_val     <= load_ext(h.funct3, bus.mem_rdata);
            end
            if (bus.rollback) begin
                for (int i = 0; i < DEPTH; i++)
                    if (q[i].vld && !q[i].committed) q[i].vld <= 1'b0;
                if (pop) q[head].vld <= 1'b0;
                head          <= head + PW'(pop);
                tail          <= head + committed_cnt[PW-1:0];
                count         <= count_rb;
                committed_cnt <= count_rb;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (q[i].rs1_busy && cap1[i][32]) begin
                        q[i].rs1_busy <= 1'b0;
                        q[i].rs1_val  <= cap1[i][31:0];
                    end
                    if (q[i].rs2_busy && cap2[i][32]) begin
                        q[i].rs2_busy <= 1'b0;
                        q[i].rs2_val  <= cap2[i][31:0];
                    end
                end
                if (commit_hit) q[commit_idx].committed <= 1'b1;
                if (pop) q[head].vld <= 1'b0;
                if (do_issue) q[tail] <= new_ent;
                head          <= head + PW'(pop);
                tail          <= tail + PW'(do_issue);
                count         <= count_n;
                committed_cnt <= committed_cnt + CW'(commit_hit) - CW'(pop_store);
            end
        end
    end
endmodule

// File: tb/tb_lsb_queue.sv
// Directed bench for lsb_queue: loads with extension, CDB capture, commit-gated stores,
// full queue, rollback with committed stores and with a dropped in-flight load.
module tb_lsb_queue;
    logic clk;
    logic rst;
`ifdef LSB_IO_WAIT_EN
    logic [3:0] io_rob_head;
`endif

    lsb_queue_if #(.ROB_W(4), .CDB_N(2)) bus ();

    lsb_queue #(.DEPTH(8), .ROB_W(4), .CDB_N(2)) dut (
        .clk(clk),
        .rst(rst),
`ifdef LSB_IO_WAIT_EN
        .io_rob_head(io_rob_head),
`endif
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_cmp = 0, n_bad = 0;
    int          n_req = 0, n_wr = 0, n_res = 0, n_overlap = 0;
    int          mem_cnt = 0, mem_lat = 3;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_rdata_cfg = 32'h0;
    logic [31:0] last_addr, last_wdata, last_res_val;
    logic [2:0]  last_len;
    logic        last_wr;
    logic [3:0]  last_res_rob;
    logic [31:0] wlog[$];

    logic [2:0]  ext_f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ext_raw [4] = '{32'h000000F0, 32'h000000F0, 32'h00008001, 32'h00008001};
    logic [31:0] ext_exp [4] = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF8001, 32'h00008001};
    logic [2:0]  ext_len [4] = '{3'd1, 3'd1, 3'd2, 3'd2};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_op(input logic st, input logic [2:0] f3, input logic [3:0] rob,
                          input logic [31:0] rs1, input logic [31:0] imm,
                          input logic b2, input logic [3:0] t2, input logic [31:0] rs2);
        bus.issue          = 1'b1;
        bus.issue_is_store = st;
        bus.issue_funct3   = f3;
        bus.issue_rob_pos  = rob;
        bus.issue_rs1_busy = 1'b0;
        bus.issue_rs1_tag  = 4'd0;
        bus.issue_rs1_val  = rs1;
        bus.issue_imm      = imm;
        bus.issue_rs2_busy = b2;
        bus.issue_rs2_tag  = t2;
        bus.issue_rs2_val  = rs2;
    endtask

    task automatic issue_op(input logic st, input logic [2:0] f3, input logic [3:0] rob,
                            input logic [31:0] rs1, input logic [31:0] imm,
                            input logic b2, input logic [3:0] t2, input logic [31:0] rs2);
        set_op(st, f3, rob, rs1, imm, b2, t2, rs2);
        tick(1);
        bus.issue = 1'b0;
    endtask

    task automatic commit(input logic [3:0] rob);
        bus.commit_store   = 1'b1;
        bus.commit_rob_pos = rob;
        tick(1);
        bus.commit_store   = 1'b0;
    endtask

    task automatic wait_req(input int target, input string tag);
        int k = 0;
        while (n_req < target && k < 40) begin
            tick(1);
            k++;
        end
        check(tag, 32'(n_req >= target), 32'd1);
    endtask

    task automatic wait_res(input int target, input string tag);
        int k = 0;
        while (n_res < target && k < 40) begin
            tick(1);
            k++;
        end
        check(tag, 32'(n_res >= target), 32'd1);
    endtask

    // Memory responder: mem_done mem_lat cycles after each request; logs requests and overlaps.
    initial begin
        bus.mem_done  = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.mem_done) mem_busy = 1'b0;
            bus.mem_done = 1'b0;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    bus.mem_done  = 1'b1;
                    bus.mem_rdata = mem_rdata_cfg;
                end
            end
            if (bus.mem_en) begin
                if (mem_busy) n_overlap++;
                mem_busy   = 1'b1;
                n_req++;
                last_addr  = bus.mem_addr;
                last_len   = bus.mem_len;
                last_wr    = bus.mem_wr;
                last_wdata = bus.mem_wdata;
                if (bus.mem_wr) begin
                    n_wr++;
                    wlog.push_back(bus.mem_wdata);
                end
                mem_cnt = mem_lat;
            end
        end
    end

    // Load result monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.result_valid) begin
                n_res++;
                last_res_val = bus.result_val;
                last_res_rob = bus.result_rob_pos;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   base, rbase, wbase;
        logic got;
        rst = 1'b1;
        bus.rdy = 1'b1;
        bus.rollback = 1'b0;
        bus.issue = 1'b0;
        bus.issue_is_store = 1'b0;
        bus.issue_funct3 = 3'd0;
        bus.issue_rob_pos = 4'd0;
        bus.issue_rs1_busy = 1'b0;
        bus.issue_rs1_tag = 4'd0;
        bus.issue_rs1_val = 32'd0;
        bus.issue_rs2_busy = 1'b0;
        bus.issue_rs2_tag = 4'd0;
        bus.issue_rs2_val = 32'd0;
        bus.issue_imm = 32'd0;
        bus.cdb_valid = 2'b00;
        bus.cdb_rob_pos = 8'h00;
        bus.cdb_val = 64'h0;
        bus.commit_store = 1'b0;
        bus.commit_rob_pos = 4'd0;
`ifdef LSB_IO_WAIT_EN
        io_rob_head = 4'd0;
`endif
        tick(3);
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_len", 32'(bus.mem_len), 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_result_valid", 32'(bus.result_valid), 32'd0);
        check("rst_result_rob", 32'(bus.result_rob_pos), 32'd0);
        check("rst_result_val", bus.result_val, 32'd0);
        check("rst_nxt_full", 32'(bus.nxt_full), 32'd0);
        rst = 1'b0;
        tick(1);

        // LW 0x100+4, raw data returned 3 cycles after the request.
        mem_lat = 3;
        mem_rdata_cfg = 32'h12345678;
        issue_op(1'b0, 3'b010, 4'd5, 32'h100, 32'd4, 1'b0, 4'd0, 32'd0);
        wait_res(1, "lw_timeout");
        check("lw_addr", last_addr, 32'h104);
        check("lw_len", 32'(last_len), 32'd4);
        check("lw_wr", 32'(last_wr), 32'd0);
        check("lw_val", last_res_val, 32'h12345678);
        check("lw_rob", 32'(last_res_rob), 32'd5);
        check("lw_req_cnt", 32'(n_req), 32'd1);

        // Sub-word loads: sign vs zero extension.
        for (int i = 0; i < 4; i++) begin
            mem_rdata_cfg = ext_raw[i];
            base = n_res;
            issue_op(1'b0, ext_f3[i], 4'(6 + i), 32'h1000, 32'(i * 4), 1'b0, 4'd0, 32'd0);
            wait_res(base + 1, "ext_timeout");
            check("ext_val", last_res_val, ext_exp[i]);
            check("ext_len", 32'(last_len), 32'(ext_len[i]));
        end

        // SW with data from CDB channel 1, held until commit.
        base = n_req;
        rbase = n_res;
        issue_op(1'b1, 3'b010, 4'd4, 32'h200, 32'h10, 1'b1, 4'd3, 32'd0);
        bus.cdb_valid = 2'b10;
        bus.cdb_rob_pos = 8'h30;
        bus.cdb_val = {32'hDEADBEEF, 32'h0};
        tick(1);
        bus.cdb_valid = 2'b00;
        tick(5);
        check("sw_no_commit_no_req", 32'(n_req), 32'(base));
        commit(4'd4);
        wait_req(base + 1, "sw_timeout");
        check("sw_wr", 32'(last_wr), 32'd1);
        check("sw_wdata", last_wdata, 32'hDEADBEEF);
        check("sw_addr", last_addr, 32'h210);
        tick(6);
        check("sw_no_result", 32'(n_res), 32'(rbase));

        // SH whose data is bypassed at issue; both channels match, channel 0 wins.
        base = n_req;
        bus.cdb_valid = 2'b11;
        bus.cdb_rob_pos = 8'h99;
        bus.cdb_val = {32'h55555555, 32'h00001234};
        issue_op(1'b1, 3'b001, 4'd10, 32'h220, 32'd0, 1'b1, 4'd9, 32'd0);
        bus.cdb_valid = 2'b00;
        commit(4'd10);
        wait_req(base + 1, "sh_timeout");
        check("sh_wdata", last_wdata, 32'h00001234);
        check("sh_len", 32'(last_len), 32'd2);
        tick(6);

        // Fill the queue with uncommitted stores, then issue into the slot freed by a pop.
        mem_lat = 2;
        base = n_req;
        for (int i = 0; i < 8; i++) begin
            set_op(1'b1, 3'b010, 4'(i), 32'h600, 32'(i * 4), 1'b0, 4'd0, 32'(i));
            #1;
            check("nxt_full_fill", 32'(bus.nxt_full), 32'(i == 7));
            @(posedge clk);
            #1;
        end
        bus.issue = 1'b0;
        #1;
        check("nxt_full_held", 32'(bus.nxt_full), 32'd1);
        commit(4'd0);
        set_op(1'b1, 3'b010, 4'd8, 32'h700, 32'd0, 1'b0, 4'd0, 32'h8);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick(1);
            if (bus.mem_done) got = 1'b1;
        end
        bus.issue = 1'b0;
        #1;
        check("full_pop_seen", 32'(got), 32'd1);
        check("nxt_full_swap", 32'(bus.nxt_full), 32'd1);
        bus.rollback = 1'b1;
        #1;
        check("nxt_full_rollback", 32'(bus.nxt_full), 32'd0);
        tick(1);
        bus.rollback = 1'b0;
        tick(5);
        check("full_req_cnt", 32'(n_req), 32'(base + 1));

        // Two committed SW and three LW; rollback with the head store in flight.
        mem_lat = 6;
        base = n_req;
        rbase = n_res;
        wbase = wlog.size();
        issue_op(1'b1, 3'b010, 4'd1, 32'h300, 32'd0, 1'b0, 4'd0, 32'hA1);
        issue_op(1'b1, 3'b010, 4'd2, 32'h304, 32'd0, 1'b0, 4'd0, 32'hA2);
        issue_op(1'b0, 3'b010, 4'd3, 32'h400, 32'd0, 1'b0, 4'd0, 32'd0);
        issue_op(1'b0, 3'b010, 4'd4, 32'h404, 32'd0, 1'b0, 4'd0, 32'd0);
        issue_op(1'b0, 3'b010, 4'd5, 32'h408, 32'd0, 1'b0, 4'd0, 32'd0);
        commit(4'd1);
        commit(4'd2);
        bus.rollback = 1'b1;
        tick(1);
        bus.rollback = 1'b0;
        tick(40);
        check("rb_req_cnt", 32'(n_req), 32'(base + 2));
        check("rb_wr_cnt", 32'(wlog.size()), 32'(wbase + 2));
        if (wlog.size() >= wbase + 2) begin
            check("rb_wdata0", wlog[wbase], 32'hA1);
            check("rb_wdata1", wlog[wbase + 1], 32'hA2);
        end
        check("rb_no_result", 32'(n_res), 32'(rbase));

        // Rollback under an in-flight load: no result; the next load still works.
        mem_lat = 4;
        base = n_req;
        rbase = n_res;
        mem_rdata_cfg = 32'hCAFEF00D;
        issue_op(1'b0, 3'b010, 4'd6, 32'h500, 32'd0, 1'b0, 4'd0, 32'd0);
        wait_req(base + 1, "drop_req_timeout");
        bus.rollback = 1'b1;
        tick(1);
        bus.rollback = 1'b0;
        tick(12);
        check("drop_no_result", 32'(n_res), 32'(rbase));
        mem_rdata_cfg = 32'h0BADF00D;
        issue_op(1'b0, 3'b010, 4'd7, 32'h504, 32'd0, 1'b0, 4'd0, 32'd0);
        wait_res(rbase + 1, "after_drop_timeout");
        check("after_drop_val", last_res_val, 32'h0BADF00D);
        check("after_drop_rob", 32'(last_res_rob), 32'd7);

        // rdy low: the issue is ignored entirely.
        tick(4);
        base = n_req;
        bus.rdy = 1'b0;
        issue_op(1'b0, 3'b010, 4'd11, 32'h800, 32'd0, 1'b0, 4'd0, 32'd0);
        tick(3);
        bus.rdy = 1'b1;
        tick(8);
        check("frozen_issue_ignored", 32'(n_req), 32'(base));

`ifdef LSB_IO_WAIT_EN
        // MMIO load waits for the ROB head.
        base = n_req;
        io_rob_head = 4'd0;
        issue_op(1'b0, 3'b010, 4'd9, 32'h30000, 32'd0, 1'b0, 4'd0, 32'd0);
        tick(5);
        check("mmio_held", 32'(n_req), 32'(base));
        io_rob_head = 4'd9;
        wait_req(base + 1, "mmio_timeout");
        check("mmio_addr", last_addr, 32'h30000);
        tick(8);
`endif

        check("no_req_overlap", 32'(n_overlap), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
